// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with WB read bypass, load-use stall detection and a saturating stall counter.
// Latency 1 cycle; Stall/Flush load a bubble in place of the ID instruction and Stall asks upstream to hold.
module id_exe_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        Rs_ID,
    input  logic [4:0]        Rt_ID,
    input  logic [4:0]        Rd_ID,
    input  logic [DATA_W-1:0] ReadData1_ID,
    input  logic [DATA_W-1:0] ReadData2_ID,
    input  logic [DATA_W-1:0] Imm_ID,
    input  logic              RegWrite_ID,
    input  logic              MemRead_ID,
    input  logic              MemWrite_ID,
    input  logic              MemToReg_ID,
    input  logic              ALUSrc_ID,
    input  logic              RegDst_ID,
    input  logic              UsesRt_ID,
    input  logic              Valid_ID,
    input  logic [3:0]        ALUOp_ID,
    input  logic              RegWrite_WB,
    input  logic [4:0]        DstReg_WB,
    input  logic [DATA_W-1:0] WriteData_WB,
    input  logic              Flush,
    input  logic              StallCntClr,
    output logic [4:0]        Rs_EXE,
    output logic [4:0]        Rt_EXE,
    output logic [4:0]        Rd_EXE,
    output logic [4:0]        DstReg_EXE,
    output logic [DATA_W-1:0] ReadData1_EXE,
    output logic [DATA_W-1:0] ReadData2_EXE,
    output logic [DATA_W-1:0] Imm_EXE,
    output logic [3:0]        ALUOp_EXE,
    output logic              RegWrite_EXE,
    output logic              MemRead_EXE,
    output logic              MemWrite_EXE,
    output logic              MemToReg_EXE,
    output logic              ALUSrc_EXE,
    output logic              Valid_EXE,
    output logic              Stall,
    output logic [15:0]       StallCount
);

    typedef struct packed {
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        dst;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [3:0]        alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic              valid;
    } exe_t;

    exe_t        exe_q, exe_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        hazard;
    logic        bubble;
    logic        wb_hit_rs;
    logic        wb_hit_rt;

    always_comb begin
        hazard = exe_q.valid & exe_q.mem_read & (exe_q.rt != 5'd0) & Valid_ID &
                 ((exe_q.rt == Rs_ID) | (UsesRt_ID & (exe_q.rt == Rt_ID)));
        Stall  = hazard & ~Flush;
        bubble = Flush | Stall | ~Valid_ID;

        // Register 0 is hard-wired, so a WB write to it must never shadow the file read.
        wb_hit_rs = RegWrite_WB & (DstReg_WB != 5'd0) & (DstReg_WB == Rs_ID);
        wb_hit_rt = RegWrite_WB & (DstReg_WB != 5'd0) & (DstReg_WB == Rt_ID);

        exe_d            = exe_q;
        exe_d.rs         = Rs_ID;
        exe_d.rt         = Rt_ID;
        exe_d.rd         = Rd_ID;
        exe_d.dst        = RegDst_ID ? Rd_ID : Rt_ID;
        exe_d.rd1        = wb_hit_rs ? WriteData_WB : ReadData1_ID;
        exe_d.rd2        = wb_hit_rt ? WriteData_WB : ReadData2_ID;
        exe_d.imm        = Imm_ID;
        exe_d.alu_op     = bubble ? 4'd0 : ALUOp_ID;
        exe_d.reg_write  = RegWrite_ID & ~bubble;
        exe_d.mem_read   = MemRead_ID & ~bubble;
        exe_d.mem_write  = MemWrite_ID & ~bubble;
        exe_d.mem_to_reg = MemToReg_ID & ~bubble;
        exe_d.alu_src    = ALUSrc_ID & ~bubble;
        exe_d.valid      = ~bubble;

        stall_count_d = stall_count_q;
        if (StallCntClr) begin
            stall_count_d = 16'd0;
        end else if (Stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q         <= '0;
            stall_count_q <= 16'd0;
        end else begin
            exe_q         <= exe_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign Rs_EXE        = exe_q.rs;
    assign Rt_EXE        = exe_q.rt;
    assign Rd_EXE        = exe_q.rd;
    assign DstReg_EXE    = exe_q.dst;
    assign ReadData1_EXE = exe_q.rd1;
    assign ReadData2_EXE = exe_q.rd2;
    assign Imm_EXE       = exe_q.imm;
    assign ALUOp_EXE     = exe_q.alu_op;
    assign RegWrite_EXE  = exe_q.reg_write;
    assign MemRead_EXE   = exe_q.mem_read;
    assign MemWrite_EXE  = exe_q.mem_write;
    assign MemToReg_EXE  = exe_q.mem_to_reg;
    assign ALUSrc_EXE    = exe_q.alu_src;
    assign Valid_EXE     = exe_q.valid;
    assign StallCount    = stall_count_q;

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed bench for id_exe_stage: pipeline load, bubbles, load-use stall, WB bypass, flush, counter, async reset.
module tb_id_exe_stage;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Rs_ID, Rt_ID, Rd_ID;
    logic [31:0] ReadData1_ID, ReadData2_ID, Imm_ID;
    logic        RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID, ALUSrc_ID, RegDst_ID, UsesRt_ID, Valid_ID;
    logic [3:0]  ALUOp_ID;
    logic        RegWrite_WB;
    logic [4:0]  DstReg_WB;
    logic [31:0] WriteData_WB;
    logic        Flush, StallCntClr;
    logic [4:0]  Rs_EXE, Rt_EXE, Rd_EXE, DstReg_EXE;
    logic [31:0] ReadData1_EXE, ReadData2_EXE, Imm_EXE;
    logic [3:0]  ALUOp_EXE;
    logic        RegWrite_EXE, MemRead_EXE, MemWrite_EXE, MemToReg_EXE, ALUSrc_EXE, Valid_EXE;
    logic        Stall;
    logic [15:0] StallCount;

    int n_tests = 0;
    int n_fail  = 0;

    id_exe_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
        .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID), .Imm_ID(Imm_ID),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
        .MemToReg_ID(MemToReg_ID), .ALUSrc_ID(ALUSrc_ID), .RegDst_ID(RegDst_ID),
        .UsesRt_ID(UsesRt_ID), .Valid_ID(Valid_ID), .ALUOp_ID(ALUOp_ID),
        .RegWrite_WB(RegWrite_WB), .DstReg_WB(DstReg_WB), .WriteData_WB(WriteData_WB),
        .Flush(Flush), .StallCntClr(StallCntClr),
        .Rs_EXE(Rs_EXE), .Rt_EXE(Rt_EXE), .Rd_EXE(Rd_EXE), .DstReg_EXE(DstReg_EXE),
        .ReadData1_EXE(ReadData1_EXE), .ReadData2_EXE(ReadData2_EXE), .Imm_EXE(Imm_EXE),
        .ALUOp_EXE(ALUOp_EXE), .RegWrite_EXE(RegWrite_EXE), .MemRead_EXE(MemRead_EXE),
        .MemWrite_EXE(MemWrite_EXE), .MemToReg_EXE(MemToReg_EXE), .ALUSrc_EXE(ALUSrc_EXE),
        .Valid_EXE(Valid_EXE), .Stall(Stall), .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        Rs_ID = 5'd0; Rt_ID = 5'd0; Rd_ID = 5'd0;
        ReadData1_ID = 32'd0; ReadData2_ID = 32'd0; Imm_ID = 32'd0;
        RegWrite_ID = 1'b0; MemRead_ID = 1'b0; MemWrite_ID = 1'b0; MemToReg_ID = 1'b0;
        ALUSrc_ID = 1'b0; RegDst_ID = 1'b0; UsesRt_ID = 1'b0; Valid_ID = 1'b0;
        ALUOp_ID = 4'd0;
        RegWrite_WB = 1'b0; DstReg_WB = 5'd0; WriteData_WB = 32'd0;
        Flush = 1'b0; StallCntClr = 1'b0;
    endtask

    task automatic id_lw(input logic [4:0] rt);
        id_clear();
        Rs_ID = 5'd1; Rt_ID = rt; Imm_ID = 32'h4;
        MemRead_ID = 1'b1; MemToReg_ID = 1'b1; RegWrite_ID = 1'b1; ALUSrc_ID = 1'b1;
        Valid_ID = 1'b1;
    endtask

    task automatic id_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_clear();
        Rs_ID = rs; Rt_ID = rt; Rd_ID = rd;
        RegWrite_ID = 1'b1; RegDst_ID = 1'b1; UsesRt_ID = 1'b1; Valid_ID = 1'b1;
        ALUOp_ID = 4'h2;
    endtask

    initial begin
        rst_n = 1'b0;
        id_clear();
        #2;
        check("rst_valid", Valid_EXE, 0);
        check("rst_count", StallCount, 0);
        check("rst_stall", Stall, 0);
        check("rst_rd1", ReadData1_EXE, 0);
        tick();
        check("rst_hold_valid", Valid_EXE, 0);
        rst_n = 1'b1;

        // Plain load of an R-type instruction
        id_add(5'd1, 5'd2, 5'd3);
        ReadData1_ID = 32'h10; ReadData2_ID = 32'h20; Imm_ID = 32'h5; ALUSrc_ID = 1'b1;
        tick();
        check("load_rd1", ReadData1_EXE, 32'h10);
        check("load_rd2", ReadData2_EXE, 32'h20);
        check("load_imm", Imm_EXE, 32'h5);
        check("load_dst", DstReg_EXE, 3);
        check("load_regwr", RegWrite_EXE, 1);
        check("load_aluop", ALUOp_EXE, 4'h2);
        check("load_valid", Valid_EXE, 1);

        // Invalid ID instruction enters as a bubble
        id_lw(5'd4);
        MemWrite_ID = 1'b1;
        Valid_ID = 1'b0;
        tick();
        check("inv_regwr", RegWrite_EXE, 0);
        check("inv_memrd", MemRead_EXE, 0);
        check("inv_memwr", MemWrite_EXE, 0);
        check("inv_valid", Valid_EXE, 0);

        // Load-use: lw $8 then add using $8
        id_lw(5'd8);
        tick();
        check("lw_memrd", MemRead_EXE, 1);
        check("lw_dst", DstReg_EXE, 8);
        id_add(5'd8, 5'd9, 5'd10);
        #1;
        check("lu_stall", Stall, 1);
        tick();
        check("lu_bubble_valid", Valid_EXE, 0);
        check("lu_bubble_regwr", RegWrite_EXE, 0);
        check("lu_stall_drop", Stall, 0);
        check("lu_count", StallCount, 1);
        tick();
        check("lu_add_valid", Valid_EXE, 1);
        check("lu_add_rs", Rs_EXE, 8);
        check("lu_add_dst", DstReg_EXE, 10);
        check("lu_count_hold", StallCount, 1);

        // No false hazard: sw sourcing Rt as store data only, and loads to $0
        id_lw(5'd8);
        tick();
        id_clear();
        Rs_ID = 5'd3; Rt_ID = 5'd8; MemWrite_ID = 1'b1; ALUSrc_ID = 1'b1; Valid_ID = 1'b1;
        #1;
        check("sw_no_stall", Stall, 0);
        UsesRt_ID = 1'b1;
        #1;
        check("rt_match_stall", Stall, 1);
        UsesRt_ID = 1'b0;
        tick();
        check("sw_loaded", MemWrite_EXE, 1);
        id_lw(5'd0);
        tick();
        id_add(5'd0, 5'd0, 5'd7);
        #1;
        check("r0_no_stall", Stall, 0);
        tick();

        // WB bypass
        id_add(5'd5, 5'd5, 5'd6);
        ReadData1_ID = 32'h1111; ReadData2_ID = 32'h2222;
        RegWrite_WB = 1'b1; DstReg_WB = 5'd5; WriteData_WB = 32'hABCD;
        tick();
        check("byp_rd1", ReadData1_EXE, 32'hABCD);
        check("byp_rd2", ReadData2_EXE, 32'hABCD);
        DstReg_WB = 5'd0;
        tick();
        check("byp_wb0_rd1", ReadData1_EXE, 32'h1111);
        Rs_ID = 5'd0;
        tick();
        check("byp_r0_rd1", ReadData1_EXE, 32'h1111);
        Rs_ID = 5'd5; DstReg_WB = 5'd5; RegWrite_WB = 1'b0;
        tick();
        check("byp_nowr_rd1", ReadData1_EXE, 32'h1111);

        // Flush concurrent with a load-use match
        id_lw(5'd8);
        tick();
        id_add(5'd8, 5'd2, 5'd3);
        Flush = 1'b1;
        #1;
        check("flush_stall", Stall, 0);
        tick();
        check("flush_valid", Valid_EXE, 0);
        check("flush_regwr", RegWrite_EXE, 0);
        check("flush_count", StallCount, 1);
        Flush = 1'b0;

        // Counter saturation from a preloaded value
        id_clear();
        force dut.stall_count_d = 16'hFFFE;
        tick();
        release dut.stall_count_d;
        check("cnt_preload", StallCount, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            id_lw(5'd8);
            tick();
            id_add(5'd8, 5'd2, 5'd3);
            tick();
            if (i == 0) check("cnt_first", StallCount, 16'hFFFF);
        end
        check("cnt_sat", StallCount, 16'hFFFF);
        id_lw(5'd8);
        tick();
        id_add(5'd8, 5'd2, 5'd3);
        StallCntClr = 1'b1;
        #1;
        check("clr_stall", Stall, 1);
        tick();
        check("clr_count", StallCount, 0);
        StallCntClr = 1'b0;

        // Asynchronous reset in the middle of a stall
        id_lw(5'd8);
        tick();
        id_add(5'd8, 5'd2, 5'd3);
        #1;
        check("ar_stall_pre", Stall, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_stall", Stall, 0);
        check("ar_valid", Valid_EXE, 0);
        check("ar_memrd", MemRead_EXE, 0);
        check("ar_rt", Rt_EXE, 0);
        check("ar_dst", DstReg_EXE, 0);
        check("ar_count", StallCount, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("ar_post_valid", Valid_EXE, 1);
        check("ar_post_rs", Rs_EXE, 8);
        check("ar_post_count", StallCount, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
